// File: rtl/deser_if.sv
// deser_if -- bundle of the serial-input / word-output signals of deser.
//
// Parameters:
//   WIDTH        number of data bits per assembled word
// Signals:
//   clear_i      synchronous abort of the word in progress
//   bit_valid_i  qualifies bit_i
//   bit_i        serial data bit (start bit, then data LSB first)
//   en_o         one-cycle strobe for a completed word (downstream register enable)
//   data_o       assembled word (downstream register data)
//   busy_o       high while a word is being received
//   perr_o       one-cycle parity-error strobe (only with DESER_PARITY_EN)
// Modports:
//   master       serial source side (drives the *_i signals)
//   slave        the deserializer (drives the *_o signals)
// Configuration macro: DESER_PARITY_EN
interface deser_if #(
    parameter int WIDTH = 8
);
    logic             clear_i;
    logic             bit_valid_i;
    logic             bit_i;
    logic             en_o;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;
`ifdef DESER_PARITY_EN
    logic             perr_o;

    modport master (
        output clear_i, bit_valid_i, bit_i,
        input  en_o, data_o, busy_o, perr_o
    );
    modport slave (
        input  clear_i, bit_valid_i, bit_i,
        output en_o, data_o, busy_o, perr_o
    );
`else
    modport master (
        output clear_i, bit_valid_i, bit_i,
        input  en_o, data_o, busy_o
    );
    modport slave (
        input  clear_i, bit_valid_i, bit_i,
        output en_o, data_o, busy_o
    );
`endif
endinterface

// File: rtl/deser.sv
// deser -- serial-to-parallel word receiver.
//
// A valid '1' in IDLE is a start bit; the next WIDTH valid bits are stored LSB
// first. The completed word is presented on data_o together with a one-cycle
// en_o strobe in the cycle after the last accepted bit. Invalid cycles stall.
//
// Parameters:
//   WIDTH   data bits per word (>= 2)
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   bus     deser_if.slave: clear_i, bit_valid_i, bit_i in;
//           en_o, data_o, busy_o (and perr_o) out
// Configuration macro: DESER_PARITY_EN
//   When defined, an even-parity bit follows the data bits (PARITY state);
//   a mismatch pulses perr_o instead of en_o and leaves data_o untouched.
module deser #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef DESER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;
`ifdef DESER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = 1'b0;
`ifdef DESER_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (bus.clear_i) begin
            // clear beats a coincident valid bit; data_o is kept
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.bit_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.bit_i) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    shift_d[cnt_q] = bus.bit_i;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        en_d    = 1'b1;
                        data_d  = shift_d;
`endif
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    if (((^shift_q) ^ bus.bit_i) == 1'b0) begin
                        en_d   = 1'b1;
                        data_d = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
`ifdef DESER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.en_o   = en_q;
    assign bus.data_o = data_q;
    assign bus.busy_o = (state_q != IDLE);
`ifdef DESER_PARITY_EN
    assign bus.perr_o = perr_q;
`endif
endmodule

// File: tb/tb_deser.sv
// tb_deser -- directed testbench for deser (WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Parity scenarios are included when DESER_PARITY_EN is defined.
module tb_deser;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    deser_if #(.WIDTH(WIDTH)) bus ();

    deser #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_count = 0;
    int en_cyc [64];
`ifdef DESER_PARITY_EN
    int perr_count = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.en_o === 1'b1) begin
            if (en_count < 64) en_cyc[en_count] = cyc;
            en_count++;
        end
`ifdef DESER_PARITY_EN
        if (bus.perr_o === 1'b1) perr_count++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid_i = 1'b1;
        bus.bit_i       = b;
        tick();
        bus.bit_valid_i = 1'b0;
        bus.bit_i       = 1'b0;
    endtask

    // start bit, 8 data bits LSB first, optional parity bit; 'stall' idle
    // cycles precede every bit after the start bit
    task automatic send_word(input logic [7:0] w, input int stall, input logic par);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            repeat (stall) tick();
            send_bit(w[i]);
        end
`ifdef DESER_PARITY_EN
        repeat (stall) tick();
        send_bit(par);
`else
        if (par) begin end
`endif
    endtask

    int base;
    int gap_exp;

    initial begin
        bus.clear_i     = 1'b0;
        bus.bit_valid_i = 1'b0;
        bus.bit_i       = 1'b0;
        rst             = 1'b1;
        repeat (2) tick();

        // reset state
        check("rst_en", 32'(bus.en_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'h00);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
`ifdef DESER_PARITY_EN
        check("rst_perr", 32'(bus.perr_o), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // a 0 in idle is not a start bit
        send_bit(1'b0);
        check("idle_zero_busy", 32'(bus.busy_o), 32'd0);

        // basic word 0xA5
        base = en_count;
        send_word(8'hA5, 0, 1'b0);
        check("basic_en", 32'(bus.en_o), 32'd1);
        check("basic_data", 32'(bus.data_o), 32'hA5);
        check("basic_busy", 32'(bus.busy_o), 32'd0);
        tick();
        check("basic_en_low", 32'(bus.en_o), 32'd0);
        check("basic_data_hold", 32'(bus.data_o), 32'hA5);
        check("basic_pulses", 32'(en_count - base), 32'd1);

        // back to back 0x3C, 0xC3: second start bit lands in the first strobe cycle
        base = en_count;
        send_word(8'h3C, 0, 1'b0);
        check("b2b_data0", 32'(bus.data_o), 32'h3C);
        send_word(8'hC3, 0, 1'b0);
        check("b2b_data1", 32'(bus.data_o), 32'hC3);
        tick();
        check("b2b_pulses", 32'(en_count - base), 32'd2);
`ifdef DESER_PARITY_EN
        gap_exp = 10;
`else
        gap_exp = 9;
`endif
        check("b2b_gap", 32'(en_cyc[base+1] - en_cyc[base]), 32'(gap_exp));

        // stall: 3 invalid cycles before every data bit
        base = en_count;
        send_word(8'hA5, 3, 1'b0);
        check("stall_en", 32'(bus.en_o), 32'd1);
        check("stall_data", 32'(bus.data_o), 32'hA5);
        tick();
        check("stall_pulses", 32'(en_count - base), 32'd1);

        // clear after 4 data bits, with a coincident valid '1' that must be dropped
        base = en_count;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("clr_busy_before", 32'(bus.busy_o), 32'd1);
        bus.clear_i     = 1'b1;
        bus.bit_valid_i = 1'b1;
        bus.bit_i       = 1'b1;
        tick();
        bus.clear_i     = 1'b0;
        bus.bit_valid_i = 1'b0;
        bus.bit_i       = 1'b0;
        check("clr_busy_after", 32'(bus.busy_o), 32'd0);
        check("clr_data_kept", 32'(bus.data_o), 32'hA5);
        send_word(8'h5A, 0, 1'b0);
        check("clr_next_data", 32'(bus.data_o), 32'h5A);
        tick();
        check("clr_pulses", 32'(en_count - base), 32'd1);

        // reset after 5 data bits: outputs drop without waiting for an edge
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_data", 32'(bus.data_o), 32'h00);
        check("arst_en", 32'(bus.en_o), 32'd0);
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        tick();
        rst = 1'b0;
        send_bit(1'b0);
        check("arst_wait_start", 32'(bus.busy_o), 32'd0);
        base = en_count;
        send_word(8'h81, 0, 1'b0);
        check("arst_next_en", 32'(bus.en_o), 32'd1);
        check("arst_next_data", 32'(bus.data_o), 32'h81);
        tick();
        check("arst_pulses", 32'(en_count - base), 32'd1);

`ifdef DESER_PARITY_EN
        // good parity, then a bad parity word must not disturb data_o
        base = en_count;
        send_word(8'hA5, 0, 1'b0);
        check("par_ok_en", 32'(bus.en_o), 32'd1);
        check("par_ok_data", 32'(bus.data_o), 32'hA5);
        check("par_ok_perr", 32'(bus.perr_o), 32'd0);
        tick();
        send_word(8'h81, 0, 1'b0);
        check("par_ok2_data", 32'(bus.data_o), 32'h81);
        tick();
        base = en_count;
        send_word(8'hA5, 0, 1'b1);
        check("par_bad_perr", 32'(bus.perr_o), 32'd1);
        check("par_bad_en", 32'(bus.en_o), 32'd0);
        check("par_bad_data", 32'(bus.data_o), 32'h81);
        tick();
        check("par_bad_perr_low", 32'(bus.perr_o), 32'd0);
        check("par_bad_pulses", 32'(en_count - base), 32'd0);
        check("par_perr_total", 32'(perr_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
